// File: rtl/add7_pkg.sv
//------------------------------------------------------------------------------
// add7_pkg : shared types and constants for the add7 kernel feeder
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package add7_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam int DEF_OPW_S = 10;
    localparam int DEF_OPW_L = 13;
    localparam int NUM_OPS   = 7;

    // Arrival order of operand words on the input stream
    localparam logic [2:0] SLOT_A = 3'd0;
    localparam logic [2:0] SLOT_B = 3'd1;
    localparam logic [2:0] SLOT_C = 3'd2;
    localparam logic [2:0] SLOT_D = 3'd3;
    localparam logic [2:0] SLOT_E = 3'd4;
    localparam logic [2:0] SLOT_F = 3'd5;
    localparam logic [2:0] SLOT_G = 3'd6;

    function automatic logic is_long_slot(input logic [2:0] idx);
        return (idx == SLOT_E) || (idx == SLOT_G);
    endfunction

endpackage

`default_nettype wire

// File: rtl/add7_feeder_if.sv
//------------------------------------------------------------------------------
// add7_feeder_if : operand-in / result-out stream handshakes of the feeder
// Rev 1.0        : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface add7_feeder_if
    import add7_pkg::*;
#(
    parameter int OPW_L = DEF_OPW_L
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW_L-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OPW_L-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

`default_nettype wire

// File: rtl/add7_feeder.sv
//------------------------------------------------------------------------------
// add7_feeder : gathers seven operand words, launches the add7 kernel and
//               returns its sum (or a zero/error word on watchdog timeout)
// Rev 1.0     : initial release
//------------------------------------------------------------------------------
`default_nettype none

module add7_feeder
    import add7_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int OPW_S   = DEF_OPW_S,
    parameter int OPW_L   = DEF_OPW_L
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    add7_feeder_if.slave          bus,
    output logic                  k_r_enable,
    output logic [OPW_S-1:0]      k_init_a,
    output logic [OPW_S-1:0]      k_init_b,
    output logic [OPW_S-1:0]      k_init_c,
    output logic [OPW_S-1:0]      k_init_d,
    output logic [OPW_L-1:0]      k_init_e,
    output logic [OPW_S-1:0]      k_init_f,
    output logic [OPW_L-1:0]      k_init_g,
    input  wire logic             k_w_enable,
    input  wire logic [OPW_L-1:0] k_result
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nx;
    logic [2:0]       idx;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_nx;
    logic             wd_expire;
    logic             job_err;
    logic             short_ovf;

    logic [OPW_S-1:0] stg_a, stg_b, stg_c, stg_d, stg_f;
    logic [OPW_L-1:0] stg_e;

    // Watchdog expires on the edge where it would reach TIMEOUT
    assign wd_nx     = wd + WD_W'(1);
    assign wd_expire = (wd_nx == WD_W'(TIMEOUT));
    assign short_ovf = !is_long_slot(idx) && (|bus.in_data[OPW_L-1:OPW_S]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        k_r_enable    = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            COLLECT: begin
                bus.in_ready = rst_n;
                if (bus.in_valid && idx == SLOT_G) state_nx = LAUNCH;
            end
            LAUNCH: begin
                k_r_enable = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (k_w_enable || wd_expire) state_nx = EMIT;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    // Operands are staged so the kernel inputs only change once a job is complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= 3'd0;
            wd           <= '0;
            job_err      <= 1'b0;
            bus.out_data <= '0;
            bus.out_err  <= 1'b0;
            {stg_a, stg_b, stg_c, stg_d, stg_e, stg_f} <= '0;
            {k_init_a, k_init_b, k_init_c, k_init_d}   <= '0;
            {k_init_e, k_init_f, k_init_g}             <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        idx <= (idx == SLOT_G) ? 3'd0 : idx + 3'd1;
                        if (short_ovf) job_err <= 1'b1;
                        case (idx)
                            SLOT_A: stg_a <= bus.in_data[OPW_S-1:0];
                            SLOT_B: stg_b <= bus.in_data[OPW_S-1:0];
                            SLOT_C: stg_c <= bus.in_data[OPW_S-1:0];
                            SLOT_D: stg_d <= bus.in_data[OPW_S-1:0];
                            SLOT_E: stg_e <= bus.in_data;
                            SLOT_F: stg_f <= bus.in_data[OPW_S-1:0];
                            default: begin
                                k_init_a <= stg_a;
                                k_init_b <= stg_b;
                                k_init_c <= stg_c;
                                k_init_d <= stg_d;
                                k_init_e <= stg_e;
                                k_init_f <= stg_f;
                                k_init_g <= bus.in_data;
                            end
                        endcase
                    end
                end
                LAUNCH: wd <= '0;
                WAIT: begin
                    wd <= wd_nx;
                    if (k_w_enable) begin
                        bus.out_data <= k_result;
                        bus.out_err  <= job_err;
                    end else if (wd_expire) begin
                        bus.out_data <= '0;
                        bus.out_err  <= 1'b1;
                        job_err      <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) job_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/add7_feeder.md
ADD7_FEEDER -- requirements
Module: add7_feeder

Interface
REQ-001 Parameter TIMEOUT, default 15: cycles WAIT tolerates without kernel w_enable before aborting.
REQ-002 Parameter OPW_S, default 10: width of short operands a, b, c, d, f.
REQ-003 Parameter OPW_L, default 13: width of long operands e, g and of the result.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream operand word valid.
REQ-007 in_ready  out  1  feeder accepts an operand word this cycle.
REQ-008 in_data  in  13  operand word; operands arrive in order a, b, c, d, e, f, g.
REQ-009 k_r_enable  out  1  one-cycle start/load pulse to the add7 kernel.
REQ-010 k_init_a..k_init_d, k_init_f  out  10 each  short operands to the kernel.
REQ-011 k_init_e, k_init_g  out  13 each  long operands to the kernel.
REQ-012 k_w_enable  in  1  kernel done flag; stays high until the next k_r_enable.
REQ-013 k_result  in  13  kernel sum, valid while k_w_enable is high.
REQ-014 out_valid  out  1  result word valid to downstream.
REQ-015 out_ready  in  1  downstream accepts the result word.
REQ-016 out_data  out  13  captured sum, or 0 on timeout.
REQ-017 out_err  out  1  set with out_data if the job had a range error or a timeout.

Function
REQ-018 The FSM SHALL have the states COLLECT, LAUNCH, WAIT and EMIT.
REQ-019 COLLECT: in_ready=1; each in_valid&in_ready transfer stores in_data into the slot selected by a 3-bit index 0..6, then increments the index.
REQ-020 A transfer at index 6 SHALL clear the index and move to LAUNCH.
REQ-021 Short slots SHALL store in_data[9:0]; nonzero in_data[12:10] on a short slot SHALL set a sticky job-error flag.
REQ-022 LAUNCH SHALL last exactly one cycle with k_r_enable=1, in_ready=0, then move to WAIT with the watchdog cleared.
REQ-023 k_init_* SHALL be registered and stay stable from LAUNCH until the next COLLECT completes.
REQ-024 WAIT: in_ready=0; the watchdog increments each cycle.
REQ-025 In WAIT, k_w_enable=1 SHALL capture k_result into out_data and move to EMIT, even in the same cycle the watchdog reaches TIMEOUT.
REQ-026 In WAIT, watchdog==TIMEOUT with k_w_enable=0 SHALL set out_data=0, force the error flag and move to EMIT.
REQ-027 EMIT: out_valid=1; out_data and out_err stay stable until out_ready=1; that cycle moves to COLLECT and clears the error flag.
REQ-028 No arithmetic SHALL be done in the feeder; k_result SHALL pass through unmodified, already wrapped mod 2^13 by the kernel.
REQ-029 Input transfers SHALL be accepted only in COLLECT; in_valid in any other state SHALL be ignored without loss, since in_ready=0.
REQ-030 Nominal latency from LAUNCH to EMIT is 9 cycles; TIMEOUT SHALL be at least 10.

Reset
REQ-031 rst_n low SHALL asynchronously force: state COLLECT, index 0, watchdog 0, error flag 0, k_r_enable 0, out_valid 0, out_data 0, out_err 0, all k_init_* 0.
REQ-032 Reset asserted mid-job (any state) SHALL discard the partial job; no out_valid SHALL follow deassertion until a new 7-word job completes.
REQ-033 in_ready SHALL be 0 while rst_n is low.

Structure
REQ-034 Package add7_pkg SHALL hold the FSM state enum, OPW_S/OPW_L defaults, operand count (7) and the slot-index-to-operand mapping constants.
REQ-035 The block SHALL be a single module; no sub-module is required; the watchdog is an inline counter sized clog2(TIMEOUT+1).

Verification
REQ-036 Words 1,2,3,4,5,6,7 with a real add7 kernel attached -> one k_r_enable pulse, out_data=28, out_err=0.
REQ-037 Short operands at 1023 and e=g=8191 -> out_data=5113 (21497 mod 8192), out_err=0.
REQ-038 First word 13'h1400 -> k_init_a=0; result = sum of the remaining operands; out_err=1.
REQ-039 Kernel stub holding k_w_enable low -> out_valid with out_data=0 and out_err=1 exactly TIMEOUT cycles after entering WAIT.
REQ-040 out_ready low for 5 cycles in EMIT -> out_valid, out_data and out_err held; in_ready=0 throughout; the next job is accepted after the handshake.
REQ-041 rst_n pulsed low during WAIT, then a fresh 7-word job -> exactly one out_valid, carrying the fresh job's sum.
